wavetable_nco: RTL and testbench

- Multi-channel, time-multiplexed numerically controlled oscillator built on a parametrised, run-time-loadable waveform table RAM (simple dual-port, inferred block RAM).
- Each channel owns a phase accumulator and a frequency increment. One `tick` (sample-rate strobe) sweeps all channels through the shared table and emits one sample per channel on a streaming output.
- Sits between the control/register interface (table load, frequency writes) and the mixer/DAC path of the synthesizer.

---
 rtl/wavetable_nco.sv | 145 ++++++++++++++
 tb/tb_wavetable_nco.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wavetable_nco.sv
// Time-multiplexed multi-channel NCO: one tick sweeps every channel's phase
// accumulator through a shared, run-time-loadable waveform table RAM.
module wavetable_nco #(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 9,
    parameter int    PHASE_W   = 24,
    parameter int    CHANNELS  = 4,
    parameter int    CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              tick,
    input  logic              phase_rst,
    input  logic              freq_we,
    input  logic [CH_W-1:0]   freq_ch,
    input  logic [PHASE_W-1:0] freq_data,
    input  logic              tbl_we,
    input  logic [ADDR_W-1:0] tbl_addr,
    input  logic [DATA_W-1:0] tbl_wdata,
    output logic              smp_valid,
    output logic [CH_W-1:0]   smp_ch,
    output logic [DATA_W-1:0] smp_data,
    output logic              busy,
    output logic              tick_drop
);

    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

    state_t state_q, state_d;

    logic [CH_W-1:0]    ch_q;
    logic [PHASE_W-1:0] phase_q [CHANNELS];
    logic [PHASE_W-1:0] inc_q   [CHANNELS];
    logic [DATA_W-1:0]  mem     [2**ADDR_W];

    logic               accept;
    logic               issue;
    logic               last_ch;
    logic               last_out;
    logic               can_accept;
    logic               freq_ok;
    logic [ADDR_W-1:0]  rd_addr;

    logic               vld_p0;
    logic [CH_W-1:0]    ch_p0;
    logic [DATA_W-1:0]  rd_data_p0;

    assign last_ch  = (ch_q == CH_W'(CHANNELS - 1));
    assign last_out = smp_valid && (smp_ch == CH_W'(CHANNELS - 1));
    // A new sweep may start on the same edge that retires the previous sweep's last sample.
    assign can_accept = !busy || last_out;
    assign freq_ok  = ({1'b0, freq_ch} < (CH_W + 1)'(CHANNELS));
    assign rd_addr  = phase_q[ch_q][PHASE_W-1 -: ADDR_W];

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        issue   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (tick && can_accept) begin
                    accept  = 1'b1;
                    state_d = SWEEP;
                end
            end
            SWEEP: begin
                issue = 1'b1;
                if (last_ch) state_d = DRAIN;
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            busy      <= 1'b0;
            tick_drop <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_drop <= tick && !accept;
            if (accept)
                ch_q <= '0;
            else if (issue && !last_ch)
                ch_q <= ch_q + 1'b1;
            if (accept)
                busy <= 1'b1;
            else if (last_out)
                busy <= 1'b0;
        end
    end

    // Clear wins over accumulation; the read address on that edge still sees the old phase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                phase_q[i] <= '0;
                inc_q[i]   <= '0;
            end
        end else begin
            if (phase_rst) begin
                for (int i = 0; i < CHANNELS; i++) phase_q[i] <= '0;
            end else if (issue) begin
                phase_q[ch_q] <= phase_q[ch_q] + inc_q[ch_q];
            end
            if (freq_we && freq_ok)
                inc_q[freq_ch] <= freq_data;
        end
    end

    // Stage p0: table RAM, registered read-before-write
    always_ff @(posedge clk) begin
        if (tbl_we) mem[tbl_addr] <= tbl_wdata;
        if (issue)  rd_data_p0    <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            ch_p0  <= '0;
        end else begin
            vld_p0 <= issue;
            if (issue) ch_p0 <= ch_q;
        end
    end

    // Stage p1: sample output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_valid <= 1'b0;
            smp_ch    <= '0;
            smp_data  <= '0;
        end else begin
            smp_valid <= vld_p0;
            if (vld_p0) begin
                smp_ch   <= ch_p0;
                smp_data <= rd_data_p0;
            end
        end
    end

endmodule

// File: tb/tb_wavetable_nco.sv
// Directed bench for wavetable_nco: expected samples are queued per sweep and
// a negedge monitor pops and compares every sample the DUT presents.
`timescale 1ns/1ps
module tb_wavetable_nco;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        phase_rst;
    logic        freq_we;
    logic [1:0]  freq_ch;
    logic [23:0] freq_data;
    logic        tbl_we;
    logic [8:0]  tbl_addr;
    logic [15:0] tbl_wdata;
    logic        smp_valid;
    logic [1:0]  smp_ch;
    logic [15:0] smp_data;
    logic        busy;
    logic        tick_drop;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] sb_q [$];
    logic [17:0] mon_item;

    always #5 clk = ~clk;

    wavetable_nco dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick      (tick),
        .phase_rst (phase_rst),
        .freq_we   (freq_we),
        .freq_ch   (freq_ch),
        .freq_data (freq_data),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_wdata (tbl_wdata),
        .smp_valid (smp_valid),
        .smp_ch    (smp_ch),
        .smp_data  (smp_data),
        .busy      (busy),
        .tick_drop (tick_drop)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (smp_valid) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_sample: got ch=%0d data=0x%0h, required no sample (t=%0t)",
                         smp_ch, smp_data, $time);
            end else begin
                mon_item = sb_q.pop_front();
                check("smp_ch", {30'd0, smp_ch}, {30'd0, mon_item[17:16]});
                check("smp_data", {16'd0, smp_data}, {16'd0, mon_item[15:0]});
            end
        end
    end

    task automatic freq_write(input logic [1:0] ch, input logic [23:0] val);
        freq_we = 1'b1; freq_ch = ch; freq_data = val;
        @(negedge clk);
        freq_we = 1'b0;
    endtask

    task automatic phase_clear();
        phase_rst = 1'b1;
        @(negedge clk);
        phase_rst = 1'b0;
    endtask

    // One sweep started at edge k. Side inputs are asserted for the single edge
    // k+j given by their index (-1 = never); observation obs sees state after edge k+obs.
    task automatic run_sweep(input logic [15:0] e0, input logic [15:0] e1,
                             input logic [15:0] e2, input logic [15:0] e3,
                             input int xt, input int fwj, input logic [23:0] fwd,
                             input int prj, input int twj,
                             input logic [8:0] twa, input logic [15:0] twd);
        int obs;
        tick      = 1'b1;
        freq_ch   = 2'd0;
        freq_data = fwd;
        freq_we   = (fwj == 0);
        phase_rst = (prj == 0);
        tbl_addr  = twa;
        tbl_wdata = twd;
        tbl_we    = (twj == 0);
        @(posedge clk);
        sb_q.push_back({2'd0, e0});
        sb_q.push_back({2'd1, e1});
        sb_q.push_back({2'd2, e2});
        sb_q.push_back({2'd3, e3});
        for (int j = 1; j <= 7; j++) begin
            @(negedge clk);
            obs = j - 1;
            if (obs == 0) check("busy_set", {31'd0, busy}, 32'd1);
            if (obs == 1) check("valid_before_k2", {31'd0, smp_valid}, 32'd0);
            if (obs == 2) check("valid_at_k2", {31'd0, smp_valid}, 32'd1);
            if (obs == 5) check("busy_last_sample", {31'd0, busy}, 32'd1);
            if (obs == 6) check("busy_clear_k6", {31'd0, busy}, 32'd0);
            if (xt > 0 && obs == xt)
                check("tick_drop_pulse", {31'd0, tick_drop}, 32'd1);
            else if (obs == 2 || obs == xt + 1)
                check("tick_drop_quiet", {31'd0, tick_drop}, 32'd0);
            tick      = (j == xt);
            freq_we   = (j == fwj);
            phase_rst = (j == prj);
            tbl_we    = (j == twj);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tick = 1'b0; phase_rst = 1'b0; freq_we = 1'b0;
        freq_ch = 2'd0; freq_data = 24'd0; tbl_we = 1'b0; tbl_addr = 9'd0; tbl_wdata = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_smp_valid", {31'd0, smp_valid}, 32'd0);
        check("rst_smp_ch", {30'd0, smp_ch}, 32'd0);
        check("rst_smp_data", {16'd0, smp_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_tick_drop", {31'd0, tick_drop}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int a = 0; a < 512; a++) begin
            tbl_we = 1'b1; tbl_addr = 9'(a); tbl_wdata = 16'(a);
            @(negedge clk);
        end
        tbl_we = 1'b0;

        // Forward step on ch0
        freq_write(2'd0, 24'h008000);
        run_sweep(16'd0, 16'd0, 16'd0, 16'd0, -1, -1, 24'd0, -1, -1, 9'd0, 16'd0);
        run_sweep(16'd1, 16'd0, 16'd0, 16'd0, -1, -1, 24'd0, -1, -1, 9'd0, 16'd0);
        run_sweep(16'd2, 16'd0, 16'd0, 16'd0, -1, -1, 24'd0, -1, -1, 9'd0, 16'd0);

        // Reverse step wraps below address 0
        phase_clear();
        freq_write(2'd0, 24'hFF8000);
        run_sweep(16'd0,   16'd0, 16'd0, 16'd0, -1, -1, 24'd0, -1, -1, 9'd0, 16'd0);
        run_sweep(16'd511, 16'd0, 16'd0, 16'd0, -1, -1, 24'd0, -1, -1, 9'd0, 16'd0);
        run_sweep(16'd510, 16'd0, 16'd0, 16'd0, -1, -1, 24'd0, -1, -1, 9'd0, 16'd0);

        // Second tick at k+2 is dropped
        run_sweep(16'd509, 16'd0, 16'd0, 16'd0, 2, -1, 24'd0, -1, -1, 9'd0, 16'd0);

        // Reset in the middle of a sweep
        tick = 1'b1;
        @(posedge clk);
        sb_q.push_back({2'd0, 16'd508});
        @(negedge clk);
        tick = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, smp_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("midrst_valid_hold", {31'd0, smp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_queue_empty", sb_q.size(), 32'd0);
        check("midrst_busy_idle", {31'd0, busy}, 32'd0);
        run_sweep(16'd0, 16'd0, 16'd0, 16'd0, -1, -1, 24'd0, -1, -1, 9'd0, 16'd0);

        // Increment write on the edge ch0 accumulates
        freq_write(2'd0, 24'h008000);
        freq_write(2'd1, 24'h010000);
        run_sweep(16'd0, 16'd0, 16'd0, 16'd0, -1, -1, 24'd0,     -1, -1, 9'd0, 16'd0);
        run_sweep(16'd1, 16'd2, 16'd0, 16'd0, -1,  1, 24'h010000, -1, -1, 9'd0, 16'd0);
        run_sweep(16'd2, 16'd4, 16'd0, 16'd0, -1, -1, 24'd0,     -1, -1, 9'd0, 16'd0);
        run_sweep(16'd4, 16'd6, 16'd0, 16'd0, -1, -1, 24'd0,     -1, -1, 9'd0, 16'd0);

        // Phase clear together with tick
        run_sweep(16'd0, 16'd0, 16'd0, 16'd0, -1, -1, 24'd0, 0, -1, 9'd0, 16'd0);
        run_sweep(16'd2, 16'd2, 16'd0, 16'd0, -1, -1, 24'd0, -1, -1, 9'd0, 16'd0);

        // Table write colliding with a read of the same address
        freq_write(2'd0, 24'h028000);
        freq_write(2'd1, 24'h000000);
        phase_clear();
        run_sweep(16'd0,    16'd0, 16'd0, 16'd0, -1, -1, 24'd0, -1, -1, 9'd0, 16'd0);
        run_sweep(16'd5,    16'd0, 16'd0, 16'd0, -1, -1, 24'd0, -1,  1, 9'd5, 16'hBEEF);
        freq_write(2'd0, 24'hFD8000);
        run_sweep(16'd10,   16'd0, 16'd0, 16'd0, -1, -1, 24'd0, -1, -1, 9'd0, 16'd0);
        run_sweep(16'hBEEF, 16'd0, 16'd0, 16'd0, -1, -1, 24'd0, -1, -1, 9'd0, 16'd0);

        repeat (4) @(negedge clk);
        check("final_queue_empty", sb_q.size(), 32'd0);
        check("final_idle", {31'd0, busy}, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
